// File: rtl/scope_ctrl.sv
// scope_ctrl: host command parser and capture/dump sequencer for the scope path.
// Parses UART command bytes into trigger configuration, arms the acquisition
// engine, then streams a sync byte plus the whole sample buffer to the UART.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for ARM; config writes allowed
// S_ARMING | acq_start held high until the engine reports busy
// S_ACQ    | acquisition running; FORCE honoured; wait for busy to fall
// S_HDR    | send SYNC_BYTE once the transmitter is free
// S_RD     | one-cycle RAM read at rdaddress
// S_TX     | send ram_q once the transmitter is free, advance address/count
module scope_ctrl #(
    parameter int              AW              = 9,
    parameter logic [7:0]      DEFAULT_LEVEL   = 8'h80,
    parameter logic [AW-1:0]   DEFAULT_PRETRIG = AW'(256),
    parameter logic [7:0]      SYNC_BYTE       = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd_data_ready,
    input  logic [7:0]    rxd_data,
    output logic          acq_start,
    input  logic          acq_busy,
    input  logic [AW-1:0] trig_addr,
    output logic          acq_abort,
    output logic          force_trig,
    output logic [7:0]    trig_level,
    output logic          trig_slope,
    output logic [AW-1:0] pretrig_depth,
    output logic [AW-1:0] rdaddress,
    output logic          rden,
    input  logic [7:0]    ram_q,
    output logic          txd_start,
    output logic [7:0]    txd_data,
    input  logic          txd_busy,
    output logic          busy,
    output logic          done
);

    localparam logic [7:0] OP_ARM     = 8'h01;
    localparam logic [7:0] OP_LEVEL   = 8'h02;
    localparam logic [7:0] OP_SLOPE   = 8'h03;
    localparam logic [7:0] OP_PRETRIG = 8'h04;
    localparam logic [7:0] OP_FORCE   = 8'h05;
    localparam logic [7:0] OP_ABORT   = 8'h06;

    // Terminal count: the whole buffer has been sent.
    localparam logic [AW:0] TERM = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {P_OP, P_ARG1, P_ARG2} pstate_t;
    typedef enum logic [2:0] {S_IDLE, S_ARMING, S_ACQ, S_HDR, S_RD, S_TX} state_t;

    pstate_t       pstate;
    state_t        state;
    logic [7:0]    opcode;
    logic [7:0]    arg_hi;
    logic [AW:0]   sample_cnt;

    logic          op_strobe;
    logic          arm_cmd;
    logic          abort_cmd;
    logic          force_cmd;
    logic          seq_idle;
    logic [AW-1:0] pre_value;

    // Single-byte commands only decode when the parser expects an opcode;
    // the same values arriving as arguments are just data.
    assign op_strobe = rxd_data_ready && (pstate == P_OP);
    assign arm_cmd   = op_strobe && (rxd_data == OP_ARM);
    assign abort_cmd = op_strobe && (rxd_data == OP_ABORT);
    assign force_cmd = op_strobe && (rxd_data == OP_FORCE);
    assign seq_idle  = (state == S_IDLE);
    assign pre_value = AW'({arg_hi, rxd_data});

    // Command parser and configuration registers; writes land only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pstate        <= P_OP;
            opcode        <= 8'h00;
            arg_hi        <= 8'h00;
            trig_level    <= DEFAULT_LEVEL;
            trig_slope    <= 1'b0;
            pretrig_depth <= DEFAULT_PRETRIG;
        end else if (rxd_data_ready) begin
            unique case (pstate)
                P_OP: begin
                    opcode <= rxd_data;
                    if (rxd_data == OP_LEVEL || rxd_data == OP_SLOPE ||
                        rxd_data == OP_PRETRIG)
                        pstate <= P_ARG1;
                end
                P_ARG1: begin
                    arg_hi <= rxd_data;
                    if (opcode == OP_PRETRIG) begin
                        pstate <= P_ARG2;
                    end else begin
                        pstate <= P_OP;
                        if (seq_idle && opcode == OP_LEVEL)
                            trig_level <= rxd_data;
                        if (seq_idle && opcode == OP_SLOPE)
                            trig_slope <= rxd_data[0];
                    end
                end
                P_ARG2: begin
                    pstate <= P_OP;
                    if (seq_idle)
                        pretrig_depth <= pre_value;
                end
                default: pstate <= P_OP;
            endcase
        end
    end

    // Capture/dump sequencer with registered handshake and transmit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acq_start  <= 1'b0;
            acq_abort  <= 1'b0;
            force_trig <= 1'b0;
            rdaddress  <= '0;
            rden       <= 1'b0;
            txd_start  <= 1'b0;
            txd_data   <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            acq_abort  <= 1'b0;
            force_trig <= 1'b0;
            txd_start  <= 1'b0;
            rden       <= 1'b0;
            // The final strobe leaves the counter at TERM, so done trails it by one cycle.
            done       <= txd_start && (sample_cnt == TERM);
            if (abort_cmd) begin
                state     <= S_IDLE;
                acq_abort <= 1'b1;
                acq_start <= 1'b0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (arm_cmd) begin
                            state     <= S_ARMING;
                            acq_start <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    S_ARMING: begin
                        if (acq_busy) begin
                            state     <= S_ACQ;
                            acq_start <= 1'b0;
                        end
                    end
                    S_ACQ: begin
                        if (force_cmd)
                            force_trig <= 1'b1;
                        if (!acq_busy) begin
                            rdaddress  <= trig_addr - pretrig_depth;
                            sample_cnt <= '0;
                            state      <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        if (!txd_busy) begin
                            txd_start <= 1'b1;
                            txd_data  <= SYNC_BYTE;
                            rden      <= 1'b1;
                            state     <= S_RD;
                        end
                    end
                    S_RD: begin
                        state <= S_TX;
                    end
                    S_TX: begin
                        if (!txd_busy) begin
                            txd_start  <= 1'b1;
                            txd_data   <= ram_q;
                            rdaddress  <= rdaddress + AW'(1);
                            sample_cnt <= sample_cnt + (AW+1)'(1);
                            if (sample_cnt == TERM - (AW+1)'(1)) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                rden  <= 1'b1;
                                state <= S_RD;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
